// File: rtl/bf2ii_rot_stage.sv
// Radix-2^2 BF2II stage: conditionally rotates the sub term by -j on the second
// half of every NBLK-beat period, then forms exact-width sums and differences.
module bf2ii_rot_stage #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 2,
    parameter int NBLK  = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    en,
    input  logic                    din_valid,
    input  logic                    sof_in,
    input  logic signed [WIDTH-1:0] din_R_add  [DEPTH],
    input  logic signed [WIDTH-1:0] din_R_sub  [DEPTH],
    input  logic signed [WIDTH-1:0] din_Q_add  [DEPTH],
    input  logic signed [WIDTH-1:0] din_Q_sub  [DEPTH],
    output logic                    dout_valid,
    output logic                    sof_out,
    output logic signed [WIDTH+1:0] dout_R_add [DEPTH],
    output logic signed [WIDTH+1:0] dout_R_sub [DEPTH],
    output logic signed [WIDTH+1:0] dout_Q_add [DEPTH],
    output logic signed [WIDTH+1:0] dout_Q_sub [DEPTH]
);

    localparam int CW = $clog2(NBLK);

    function automatic logic signed [WIDTH:0] ext_sub(input logic signed [WIDTH-1:0] x);
        return {x[WIDTH-1], x};
    endfunction

    function automatic logic signed [WIDTH+1:0] ext_add(input logic signed [WIDTH-1:0] x);
        return {{2{x[WIDTH-1]}}, x};
    endfunction

    function automatic logic signed [WIDTH+1:0] ext_rot(input logic signed [WIDTH:0] x);
        return {x[WIDTH], x};
    endfunction

    logic [CW-1:0] cnt;
    logic [CW-1:0] phase;
    logic          rot;
    logic          acc;

    logic signed [WIDTH:0]   sr_n  [DEPTH];
    logic signed [WIDTH:0]   sq_n  [DEPTH];
    logic signed [WIDTH-1:0] ar_p1 [DEPTH];
    logic signed [WIDTH-1:0] aq_p1 [DEPTH];
    logic signed [WIDTH:0]   sr_p1 [DEPTH];
    logic signed [WIDTH:0]   sq_p1 [DEPTH];
    logic                    vld_p1, sof_p1;

    logic signed [WIDTH+1:0] ra_p2 [DEPTH];
    logic signed [WIDTH+1:0] rs_p2 [DEPTH];
    logic signed [WIDTH+1:0] qa_p2 [DEPTH];
    logic signed [WIDTH+1:0] qs_p2 [DEPTH];
    logic                    vld_p2, sof_p2;

    assign acc   = en & din_valid;
    assign phase = sof_in ? '0 : cnt;
    // NBLK is a power of two, so the MSB of the phase marks the second half.
    assign rot   = phase[CW-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else if (acc)
            cnt <= phase + CW'(1);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            sr_n[i] = ext_sub(din_R_sub[i]);
            sq_n[i] = ext_sub(din_Q_sub[i]);
            if (rot) begin
                sr_n[i] = ext_sub(din_Q_sub[i]);
                sq_n[i] = -ext_sub(din_R_sub[i]);
            end
        end
    end

    // Stage 1: operand alignment and -j rotation
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                ar_p1[i] <= '0;
                aq_p1[i] <= '0;
                sr_p1[i] <= '0;
                sq_p1[i] <= '0;
            end
        end else if (acc) begin
            for (int i = 0; i < DEPTH; i++) begin
                ar_p1[i] <= din_R_add[i];
                aq_p1[i] <= din_Q_add[i];
                sr_p1[i] <= sr_n[i];
                sq_p1[i] <= sq_n[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1 <= 1'b0;
            sof_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            sof_p2 <= 1'b0;
        end else if (en) begin
            vld_p1 <= din_valid;
            sof_p1 <= din_valid & sof_in;
            vld_p2 <= vld_p1;
            sof_p2 <= sof_p1;
        end
    end

    // Stage 2: full-precision butterfly, two guard bits absorb the growth
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                ra_p2[i] <= '0;
                rs_p2[i] <= '0;
                qa_p2[i] <= '0;
                qs_p2[i] <= '0;
            end
        end else if (en) begin
            for (int i = 0; i < DEPTH; i++) begin
                ra_p2[i] <= ext_add(ar_p1[i]) + ext_rot(sr_p1[i]);
                rs_p2[i] <= ext_add(ar_p1[i]) - ext_rot(sr_p1[i]);
                qa_p2[i] <= ext_add(aq_p1[i]) + ext_rot(sq_p1[i]);
                qs_p2[i] <= ext_add(aq_p1[i]) - ext_rot(sq_p1[i]);
            end
        end
    end

    assign dout_valid = vld_p2;
    assign sof_out    = sof_p2;
    assign dout_R_add = ra_p2;
    assign dout_R_sub = rs_p2;
    assign dout_Q_add = qa_p2;
    assign dout_Q_sub = qs_p2;

endmodule

// File: tb/tb_bf2ii_rot_stage.sv
// Directed testbench for bf2ii_rot_stage: reset, pass-through, rotation, extremes,
// stall, resync and reset with beats in flight.
module tb_bf2ii_rot_stage;

    localparam int W  = 14;
    localparam int D  = 2;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic rstn, en, din_valid, sof_in;
    logic signed [W-1:0] din_R_add  [D];
    logic signed [W-1:0] din_R_sub  [D];
    logic signed [W-1:0] din_Q_add  [D];
    logic signed [W-1:0] din_Q_sub  [D];
    logic                dout_valid, sof_out;
    logic signed [W+1:0] dout_R_add [D];
    logic signed [W+1:0] dout_R_sub [D];
    logic signed [W+1:0] dout_Q_add [D];
    logic signed [W+1:0] dout_Q_sub [D];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc_n  = 0;

    typedef struct {
        logic sof;
        int   ra, rs, qa, qs;
        int   cyc;
    } obs_t;
    obs_t q[$];
    obs_t o_tmp;
    logic en_smp;

    bf2ii_rot_stage #(.WIDTH(W), .DEPTH(D), .NBLK(NB)) dut (
        .clk(clk), .rstn(rstn), .en(en), .din_valid(din_valid), .sof_in(sof_in),
        .din_R_add(din_R_add), .din_R_sub(din_R_sub),
        .din_Q_add(din_Q_add), .din_Q_sub(din_Q_sub),
        .dout_valid(dout_valid), .sof_out(sof_out),
        .dout_R_add(dout_R_add), .dout_R_sub(dout_R_sub),
        .dout_Q_add(dout_Q_add), .dout_Q_sub(dout_Q_sub)
    );

    always #5 clk = ~clk;

    // Record lane-0 output beats on enabled edges only, so held outputs during a stall are not counted twice.
    always @(posedge clk) begin
        en_smp = en;
        cyc_n++;
        #1;
        if (en_smp && dout_valid) begin
            o_tmp.sof = sof_out;
            o_tmp.ra  = int'(dout_R_add[0]);
            o_tmp.rs  = int'(dout_R_sub[0]);
            o_tmp.qa  = int'(dout_Q_add[0]);
            o_tmp.qs  = int'(dout_Q_sub[0]);
            o_tmp.cyc = cyc_n;
            q.push_back(o_tmp);
        end
    end

    // Lane 1 carries the negated lane-0 vector.
    task automatic beat(input logic e, input logic v, input logic s,
                        input int ar, input int aq, input int rsb, input int qsb);
        en = e; din_valid = v; sof_in = s;
        din_R_add[0] = 14'(ar);  din_Q_add[0] = 14'(aq);
        din_R_sub[0] = 14'(rsb); din_Q_sub[0] = 14'(qsb);
        din_R_add[1] = 14'(-ar);  din_Q_add[1] = 14'(-aq);
        din_R_sub[1] = 14'(-rsb); din_Q_sub[1] = 14'(-qsb);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) beat(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        beat(1'b1, 1'b1, 1'b1, 5, 3, 2, 1);
        beat(1'b1, 1'b1, 1'b1, 5, 3, 2, 1);
        n_chk++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", dout_valid); end
        n_chk++; if (sof_out !== 1'b0) begin n_fail++; $display("FAIL rst_sof got=%b exp=0", sof_out); end
        n_chk++; if (int'(dout_R_add[0]) !== 0) begin n_fail++; $display("FAIL rst_R_add got=%0d exp=0", dout_R_add[0]); end
        n_chk++; if (int'(dout_R_sub[0]) !== 0) begin n_fail++; $display("FAIL rst_R_sub got=%0d exp=0", dout_R_sub[0]); end
        n_chk++; if (int'(dout_Q_add[0]) !== 0) begin n_fail++; $display("FAIL rst_Q_add got=%0d exp=0", dout_Q_add[0]); end
        n_chk++; if (int'(dout_Q_sub[1]) !== 0) begin n_fail++; $display("FAIL rst_Q_sub1 got=%0d exp=0", dout_Q_sub[1]); end
        din_valid = 1'b0;
        rstn = 1'b1;
        idle(1);
    endtask

    task automatic test_passthrough();
        beat(1'b1, 1'b1, 1'b1, 5, 3, 2, 1);
        n_chk++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL pt_latency1 got=%b exp=0", dout_valid); end
        idle(1);
        n_chk++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL pt_valid got=%b exp=1", dout_valid); end
        n_chk++; if (sof_out !== 1'b1) begin n_fail++; $display("FAIL pt_sof got=%b exp=1", sof_out); end
        n_chk++; if (int'(dout_R_add[0]) !== 7) begin n_fail++; $display("FAIL pt_R_add0 got=%0d exp=7", dout_R_add[0]); end
        n_chk++; if (int'(dout_R_sub[0]) !== 3) begin n_fail++; $display("FAIL pt_R_sub0 got=%0d exp=3", dout_R_sub[0]); end
        n_chk++; if (int'(dout_Q_add[0]) !== 4) begin n_fail++; $display("FAIL pt_Q_add0 got=%0d exp=4", dout_Q_add[0]); end
        n_chk++; if (int'(dout_Q_sub[0]) !== 2) begin n_fail++; $display("FAIL pt_Q_sub0 got=%0d exp=2", dout_Q_sub[0]); end
        n_chk++; if (int'(dout_R_add[1]) !== -7) begin n_fail++; $display("FAIL pt_R_add1 got=%0d exp=-7", dout_R_add[1]); end
        n_chk++; if (int'(dout_R_sub[1]) !== -3) begin n_fail++; $display("FAIL pt_R_sub1 got=%0d exp=-3", dout_R_sub[1]); end
        n_chk++; if (int'(dout_Q_add[1]) !== -4) begin n_fail++; $display("FAIL pt_Q_add1 got=%0d exp=-4", dout_Q_add[1]); end
        n_chk++; if (int'(dout_Q_sub[1]) !== -2) begin n_fail++; $display("FAIL pt_Q_sub1 got=%0d exp=-2", dout_Q_sub[1]); end
        idle(1);
        n_chk++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL pt_valid_drop got=%b exp=0", dout_valid); end
    endtask

    task automatic test_rotation();
        int exp_ra[4] = '{7, 7, 6, 6};
        int exp_rs[4] = '{3, 3, 4, 4};
        int exp_qa[4] = '{4, 4, 1, 1};
        int exp_qs[4] = '{2, 2, 5, 5};
        q.delete();
        beat(1'b1, 1'b1, 1'b1, 5, 3, 2, 1);
        repeat (3) beat(1'b1, 1'b1, 1'b0, 5, 3, 2, 1);
        idle(3);
        n_chk++; if (q.size() !== 4) begin n_fail++; $display("FAIL rot_count got=%0d exp=4", q.size()); end
        if (q.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                n_chk++; if (q[k].ra !== exp_ra[k]) begin n_fail++; $display("FAIL rot_R_add[%0d] got=%0d exp=%0d", k, q[k].ra, exp_ra[k]); end
                n_chk++; if (q[k].rs !== exp_rs[k]) begin n_fail++; $display("FAIL rot_R_sub[%0d] got=%0d exp=%0d", k, q[k].rs, exp_rs[k]); end
                n_chk++; if (q[k].qa !== exp_qa[k]) begin n_fail++; $display("FAIL rot_Q_add[%0d] got=%0d exp=%0d", k, q[k].qa, exp_qa[k]); end
                n_chk++; if (q[k].qs !== exp_qs[k]) begin n_fail++; $display("FAIL rot_Q_sub[%0d] got=%0d exp=%0d", k, q[k].qs, exp_qs[k]); end
                n_chk++; if (q[k].sof !== (k == 0)) begin n_fail++; $display("FAIL rot_sof[%0d] got=%b exp=%b", k, q[k].sof, (k == 0)); end
            end
        end
    endtask

    task automatic test_extremes();
        q.delete();
        beat(1'b1, 1'b1, 1'b1, 0, 0, 0, 0);
        beat(1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
        beat(1'b1, 1'b1, 1'b0, 0, -8192, -8192, 0);
        beat(1'b1, 1'b1, 1'b0, 8191, 0, 0, 8191);
        idle(3);
        n_chk++; if (q.size() !== 4) begin n_fail++; $display("FAIL ext_count got=%0d exp=4", q.size()); end
        if (q.size() == 4) begin
            n_chk++; if (q[2].qs !== -16384) begin n_fail++; $display("FAIL ext_Q_sub got=%0d exp=-16384", q[2].qs); end
            n_chk++; if (q[2].qa !== 0) begin n_fail++; $display("FAIL ext_Q_add got=%0d exp=0", q[2].qa); end
            n_chk++; if (q[2].ra !== 0) begin n_fail++; $display("FAIL ext_R_add got=%0d exp=0", q[2].ra); end
            n_chk++; if (q[3].ra !== 16382) begin n_fail++; $display("FAIL ext_R_add_max got=%0d exp=16382", q[3].ra); end
            n_chk++; if (q[3].rs !== 0) begin n_fail++; $display("FAIL ext_R_sub_max got=%0d exp=0", q[3].rs); end
        end
    endtask

    task automatic test_stall();
        int ar, aq, rsb, qsb, sr, sq, gap;
        q.delete();
        for (int k = 0; k < 8; k++) begin
            if (k == 4) repeat (3) beat(1'b0, 1'b1, 1'b0, 10*k - 30, 7*k - 20, 3 - k, 2*k - 5);
            beat(1'b1, 1'b1, (k == 0), 10*k - 30, 7*k - 20, 3 - k, 2*k - 5);
        end
        idle(3);
        n_chk++; if (q.size() !== 8) begin n_fail++; $display("FAIL stall_count got=%0d exp=8", q.size()); end
        if (q.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                ar = 10*k - 30; aq = 7*k - 20; rsb = 3 - k; qsb = 2*k - 5;
                sr = ((k % 4) >= 2) ? qsb  : rsb;
                sq = ((k % 4) >= 2) ? -rsb : qsb;
                n_chk++; if (q[k].ra !== ar + sr) begin n_fail++; $display("FAIL stall_R_add[%0d] got=%0d exp=%0d", k, q[k].ra, ar + sr); end
                n_chk++; if (q[k].rs !== ar - sr) begin n_fail++; $display("FAIL stall_R_sub[%0d] got=%0d exp=%0d", k, q[k].rs, ar - sr); end
                n_chk++; if (q[k].qa !== aq + sq) begin n_fail++; $display("FAIL stall_Q_add[%0d] got=%0d exp=%0d", k, q[k].qa, aq + sq); end
                n_chk++; if (q[k].qs !== aq - sq) begin n_fail++; $display("FAIL stall_Q_sub[%0d] got=%0d exp=%0d", k, q[k].qs, aq - sq); end
                if (k > 0) begin
                    gap = (k == 3) ? 4 : 1;
                    n_chk++; if (q[k].cyc - q[k-1].cyc !== gap) begin n_fail++; $display("FAIL stall_gap[%0d] got=%0d exp=%0d", k, q[k].cyc - q[k-1].cyc, gap); end
                end
            end
        end
    endtask

    task automatic test_resync();
        int   exp_ra[5]  = '{7, 7, 7, 6, 6};
        int   exp_qs[5]  = '{2, 2, 2, 5, 5};
        logic exp_sof[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        q.delete();
        beat(1'b1, 1'b1, 1'b1, 5, 3, 2, 1);
        beat(1'b1, 1'b1, 1'b1, 5, 3, 2, 1);
        repeat (3) beat(1'b1, 1'b1, 1'b0, 5, 3, 2, 1);
        idle(3);
        n_chk++; if (q.size() !== 5) begin n_fail++; $display("FAIL resync_count got=%0d exp=5", q.size()); end
        if (q.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                n_chk++; if (q[k].ra !== exp_ra[k]) begin n_fail++; $display("FAIL resync_R_add[%0d] got=%0d exp=%0d", k, q[k].ra, exp_ra[k]); end
                n_chk++; if (q[k].qs !== exp_qs[k]) begin n_fail++; $display("FAIL resync_Q_sub[%0d] got=%0d exp=%0d", k, q[k].qs, exp_qs[k]); end
                n_chk++; if (q[k].sof !== exp_sof[k]) begin n_fail++; $display("FAIL resync_sof[%0d] got=%b exp=%b", k, q[k].sof, exp_sof[k]); end
            end
        end
    endtask

    task automatic test_reset_inflight();
        beat(1'b1, 1'b1, 1'b1, 5, 3, 2, 1);
        beat(1'b1, 1'b1, 1'b0, 5, 3, 2, 1);
        din_valid = 1'b0;
        rstn = 1'b0;
        #1;
        n_chk++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got=%b exp=0", dout_valid); end
        n_chk++; if (sof_out !== 1'b0) begin n_fail++; $display("FAIL arst_sof got=%b exp=0", sof_out); end
        n_chk++; if (int'(dout_R_add[0]) !== 0) begin n_fail++; $display("FAIL arst_R_add got=%0d exp=0", dout_R_add[0]); end
        n_chk++; if (int'(dout_Q_sub[0]) !== 0) begin n_fail++; $display("FAIL arst_Q_sub got=%0d exp=0", dout_Q_sub[0]); end
        q.delete();
        idle(2);
        rstn = 1'b1;
        idle(4);
        n_chk++; if (q.size() !== 0) begin n_fail++; $display("FAIL arst_no_valid got=%0d exp=0", q.size()); end
        q.delete();
        repeat (3) beat(1'b1, 1'b1, 1'b0, 5, 3, 2, 1);
        idle(3);
        n_chk++; if (q.size() !== 3) begin n_fail++; $display("FAIL post_rst_count got=%0d exp=3", q.size()); end
        if (q.size() == 3) begin
            n_chk++; if (q[0].ra !== 7) begin n_fail++; $display("FAIL post_rst_p0 got=%0d exp=7", q[0].ra); end
            n_chk++; if (q[1].ra !== 7) begin n_fail++; $display("FAIL post_rst_p1 got=%0d exp=7", q[1].ra); end
            n_chk++; if (q[2].ra !== 6) begin n_fail++; $display("FAIL post_rst_p2 got=%0d exp=6", q[2].ra); end
            n_chk++; if (q[0].sof !== 1'b0) begin n_fail++; $display("FAIL post_rst_sof got=%b exp=0", q[0].sof); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; en = 1'b0; din_valid = 1'b0; sof_in = 1'b0;
        for (int i = 0; i < D; i++) begin
            din_R_add[i] = '0; din_R_sub[i] = '0; din_Q_add[i] = '0; din_Q_sub[i] = '0;
        end
        @(posedge clk); #1;
        test_reset();
        test_passthrough();
        test_rotation();
        test_extremes();
        test_stall();
        test_resync();
        test_reset_inflight();
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
